// File: rtl/bram_bist_engine.sv
// BIST engine for one write/read port pair of a split BRAM.
// It writes an address-derived pattern over a window of addresses, reads the
// window back and counts the words that do not match.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | out of reset, every output low, waiting for start
// S_WRITE | one write per cycle, ADDR_BASE up to the last address
// S_READ  | one read per cycle over the same window, addresses tracked
// S_DRAIN | RD_LATENCY cycles with REN low while the last reads compare
// S_DONE  | result held (done/pass/err_cnt); start runs the test again
module bram_bist_engine #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_BASE  = 0,
  parameter int DEPTH      = 512,
  parameter int SEED       = 0,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  WEN,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  REN,
  output logic [ADDR_WIDTH-1:0] RD_ADDR,
  input  logic [DATA_WIDTH-1:0] RDATA
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(ADDR_BASE);
  // End of the window is found by equality, so the counter never has to wrap.
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(ADDR_BASE + DEPTH - 1);
  localparam logic [1:0]            DRAIN_INIT = 2'(RD_LATENCY - 1);

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]   first_err_q, first_err_d;
  logic                    wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    ren_q, ren_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [1:0]              drain_cnt_q, drain_cnt_d;

  // Expected-address pipeline: entry 0 is loaded on the edge that raises REN,
  // so the tail lines up with the RDATA sample RD_LATENCY edges later.
  logic                    pipe_vld_q  [RD_LATENCY];
  logic                    pipe_vld_d  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0]   pipe_addr_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0]   pipe_addr_d [RD_LATENCY];

  logic                    mismatch;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] v;
    v = 32'(a) + 32'(SEED);
    return DATA_WIDTH'(v | (v << 20) | 32'h0005_5000);
  endfunction

  // Shift the expected-address pipeline alongside the read issue.
  always_comb begin
    pipe_vld_d[0]  = ren_d;
    pipe_addr_d[0] = rd_addr_d;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
  end

  // Next-state, output and result logic.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    wen_d       = 1'b0;
    wr_addr_d   = wr_addr_q;
    wdata_d     = wdata_q;
    ren_d       = 1'b0;
    rd_addr_d   = rd_addr_q;
    drain_cnt_d = drain_cnt_q;

    // 4-state compare so an X on RDATA is reported as a mismatch.
    mismatch = pipe_vld_q[RD_LATENCY-1] &&
               (RDATA !== pat(pipe_addr_q[RD_LATENCY-1]));
    if (mismatch) begin
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
      if (err_cnt_q == 16'd0) begin
        first_err_d = pipe_addr_q[RD_LATENCY-1];
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WRITE;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_cnt_d   = 16'd0;
          first_err_d = '0;
          wen_d       = 1'b1;
          wr_addr_d   = ADDR_FIRST;
          wdata_d     = pat(ADDR_FIRST);
        end
      end
      S_WRITE: begin
        if (wr_addr_q == ADDR_LAST) begin
          state_d   = S_READ;
          ren_d     = 1'b1;
          rd_addr_d = ADDR_FIRST;
        end else begin
          wen_d     = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
          wdata_d   = pat(wr_addr_q + ADDR_WIDTH'(1));
        end
      end
      S_READ: begin
        if (rd_addr_q == ADDR_LAST) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_INIT;
        end else begin
          ren_d     = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == 2'd0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == 16'd0);
        end else begin
          drain_cnt_d = drain_cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register all state and outputs; reset forces everything back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= 16'd0;
      first_err_q <= '0;
      wen_q       <= 1'b0;
      wr_addr_q   <= '0;
      wdata_q     <= '0;
      ren_q       <= 1'b0;
      rd_addr_q   <= '0;
      drain_cnt_q <= 2'd0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_addr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      wen_q       <= wen_d;
      wr_addr_q   <= wr_addr_d;
      wdata_q     <= wdata_d;
      ren_q       <= ren_d;
      rd_addr_q   <= rd_addr_d;
      drain_cnt_q <= drain_cnt_d;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_d[i];
        pipe_addr_q[i] <= pipe_addr_d[i];
      end
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign WEN            = wen_q;
  assign WR_ADDR        = wr_addr_q;
  assign WDATA          = wdata_q;
  assign REN            = ren_q;
  assign RD_ADDR        = rd_addr_q;

endmodule

// File: tb/tb_bram_bist_engine.sv
// Bench for bram_bist_engine: two instances (read latency 1 and 2) against
// behavioural BRAM models with injectable bit-0 read faults.
module tb_bram_bist_engine;
  localparam int AW    = 4;
  localparam int DW    = 18;
  localparam int BASE  = 8;
  localparam int DEPTH = 8;
  localparam int SEED  = 2;

  typedef struct {
    int done_edge;
    int err;
    int first;
    bit pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n_s [2];
  logic          start_s [2];
  logic          busy_s  [2];
  logic          done_s  [2];
  logic          pass_s  [2];
  logic [15:0]   err_s   [2];
  logic [AW-1:0] ferr_s  [2];
  logic          wen_s   [2];
  logic [AW-1:0] wra_s   [2];
  logic [DW-1:0] wd_s    [2];
  logic          ren_s   [2];
  logic [AW-1:0] rda_s   [2];
  logic [DW-1:0] rdata0, rdata1;
  logic [15:0]   fault_s [2];
  logic [DW-1:0] mem0 [16];
  logic [DW-1:0] mem1 [16];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  exp_t q0[$];
  exp_t q1[$];

  bram_bist_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_BASE(BASE),
                     .DEPTH(DEPTH), .SEED(SEED), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n_s[0]), .start(start_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .pass(pass_s[0]), .err_cnt(err_s[0]),
    .first_err_addr(ferr_s[0]), .WEN(wen_s[0]), .WR_ADDR(wra_s[0]),
    .WDATA(wd_s[0]), .REN(ren_s[0]), .RD_ADDR(rda_s[0]), .RDATA(rdata0));

  bram_bist_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_BASE(BASE),
                     .DEPTH(DEPTH), .SEED(SEED), .RD_LATENCY(2)) dut_b (
    .clk(clk), .rst_n(rst_n_s[1]), .start(start_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .pass(pass_s[1]), .err_cnt(err_s[1]),
    .first_err_addr(ferr_s[1]), .WEN(wen_s[1]), .WR_ADDR(wra_s[1]),
    .WDATA(wd_s[1]), .REN(ren_s[1]), .RD_ADDR(rda_s[1]), .RDATA(rdata1));

  // BRAM models: latency 1 reads straight through, latency 2 adds one register.
  always @(posedge clk) begin
    if (wen_s[0]) mem0[wra_s[0]] <= wd_s[0];
    if (wen_s[1]) mem1[wra_s[1]] <= wd_s[1];
    rdata1 <= mem1[rda_s[1]] ^ DW'(fault_s[1][rda_s[1]]);
  end
  assign rdata0 = mem0[rda_s[0]] ^ DW'(fault_s[0][rda_s[0]]);

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] ref_pat(input int a);
    int unsigned v;
    int unsigned w;
    v = a + SEED;
    w = v | (v << 20) | 32'h55000;
    return w[DW-1:0];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int outs_or(input int i);
    return int'(busy_s[i] | done_s[i] | pass_s[i] | (|err_s[i]) | (|ferr_s[i]) |
                wen_s[i] | (|wra_s[i]) | (|wd_s[i]) | ren_s[i] | (|rda_s[i]));
  endfunction

  // Monitor: checks write/read streams each cycle and pops the scoreboard on done.
  int            wen_cnt [2];
  int            ren_cnt [2];
  logic          wen_prev [2];
  logic          done_prev [2];
  logic [AW-1:0] last_wa [2];
  logic [DW-1:0] last_wd [2];
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n_s[i]) begin
        wen_cnt[i] = 0; ren_cnt[i] = 0; wen_prev[i] = 1'b0; done_prev[i] = 1'b0;
      end else begin
        if (wen_s[i] && ren_s[i]) chk($sformatf("wen_ren_both_%0d", i), 1, 0);
        if (wen_s[i]) begin
          if (!wen_prev[i]) begin
            wen_cnt[i] = 0; ren_cnt[i] = 0;
            chk($sformatf("first_wr_addr_%0d", i), int'(wra_s[i]), 8);
            chk($sformatf("first_wdata_%0d", i), int'(wd_s[i]), 'h1500A);
          end
          chk($sformatf("wr_addr_%0d", i), int'(wra_s[i]), BASE + wen_cnt[i]);
          chk($sformatf("wdata_%0d", i), int'(wd_s[i]), int'(ref_pat(int'(wra_s[i]))));
          wen_cnt[i]++;
          last_wa[i] = wra_s[i];
          last_wd[i] = wd_s[i];
        end
        if (ren_s[i]) begin
          chk($sformatf("rd_addr_%0d", i), int'(rda_s[i]), BASE + ren_cnt[i]);
          ren_cnt[i]++;
        end
        if (done_s[i] && !done_prev[i]) begin
          have = 1'b0;
          if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          if (!have) begin
            chk($sformatf("unexpected_done_%0d", i), 1, 0);
          end else begin
            chk($sformatf("done_edge_%0d", i), cyc, e.done_edge);
            chk($sformatf("err_cnt_%0d", i), int'(err_s[i]), e.err);
            chk($sformatf("first_err_addr_%0d", i), int'(ferr_s[i]), e.first);
            chk($sformatf("pass_%0d", i), int'(pass_s[i]), int'(e.pass));
            chk($sformatf("busy_at_done_%0d", i), int'(busy_s[i]), 0);
            chk($sformatf("wen_cycles_%0d", i), wen_cnt[i], DEPTH);
            chk($sformatf("ren_cycles_%0d", i), ren_cnt[i], DEPTH);
            chk($sformatf("last_wr_addr_%0d", i), int'(last_wa[i]), 15);
            chk($sformatf("last_wdata_%0d", i), int'(last_wd[i]), 'h15011);
          end
        end
        wen_prev[i]  = wen_s[i];
        done_prev[i] = done_s[i];
      end
    end
  end

  task automatic wait_done(input int i);
    int t;
    t = 0;
    while (!done_s[i] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk($sformatf("done_timeout_%0d", i), 0, 1);
    @(negedge clk);
  endtask

  // One full run: expected result comes from the fault set, not from the DUT.
  task automatic run(input int i, input logic [15:0] mask, input bit poke);
    exp_t e;
    int   n;
    int   first;
    fault_s[i] = mask;
    n = 0;
    first = 0;
    for (int a = BASE + DEPTH - 1; a >= BASE; a--) begin
      if (mask[a]) begin
        n++;
        first = a;
      end
    end
    @(negedge clk);
    start_s[i] = 1'b1;
    e.done_edge = cyc + 1 + 2 * DEPTH + (i == 0 ? 1 : 2);
    e.err   = n;
    e.first = first;
    e.pass  = (n == 0);
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    start_s[i] = 1'b0;
    chk($sformatf("busy_after_start_%0d", i), int'(busy_s[i]), 1);
    chk($sformatf("done_cleared_%0d", i), int'(done_s[i]), 0);
    if (poke) begin
      repeat ($urandom_range(1, 14)) @(negedge clk);
      start_s[i] = 1'b1;
      @(negedge clk);
      start_s[i] = 1'b0;
    end
    wait_done(i);
  endtask

  initial begin
    logic [15:0] m;
    int          sel;
    rst_n_s[0] = 1'b0; rst_n_s[1] = 1'b0;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    fault_s[0] = '0;   fault_s[1] = '0;

    // Reset held with random start: all outputs stay low.
    repeat (5) begin
      @(negedge clk);
      start_s[0] = 1'($urandom_range(0, 1));
      start_s[1] = 1'($urandom_range(0, 1));
      #1;
      chk("reset_outputs_0", outs_or(0), 0);
      chk("reset_outputs_1", outs_or(1), 0);
    end
    @(negedge clk);
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    #2;
    rst_n_s[0] = 1'b1; rst_n_s[1] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_hold_0", outs_or(0), 0);
      chk("idle_hold_1", outs_or(1), 0);
    end

    run(0, 16'h0000, 1'b0);                       // golden run
    run(0, 16'h0400, 1'b0);                       // bit-0 fault at address 10
    run(1, 16'h3200, 1'b0);                       // faults at 9, 12, 13
    run(0, 16'h0000, 1'b1);                       // start while busy ignored

    // Reset during the third write cycle, then a clean rerun.
    fault_s[0] = '0;
    @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("wen_before_reset", int'(wen_s[0]), 1);
    #2;
    rst_n_s[0] = 1'b0;
    #1;
    chk("midrun_reset_outputs", outs_or(0), 0);
    chk("midrun_reset_busy", int'(busy_s[0]), 0);
    @(negedge clk);
    #2;
    rst_n_s[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", outs_or(0), 0);
    run(0, 16'h0000, 1'b0);

    // Randomized runs: fault sets may include addresses outside the window.
    repeat (12) begin
      sel = $urandom_range(0, 1);
      m = 16'($urandom);
      if ($urandom_range(0, 2) == 0) m = '0;
      run(sel, m, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty_0", q0.size(), 0);
    chk("scoreboard_empty_1", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
